// File: rtl/psg_pkg.sv
// Shared constants and helpers for the PSG tone bank.
// Optional noise source is controlled by the PSG_NOISE_EN macro (see psg_tone_bank).
package psg_pkg;

    localparam logic WR_SEL_PERIOD = 1'b0;
    localparam logic WR_SEL_VOL    = 1'b1;

    localparam int        LFSR_W    = 17;
    localparam logic [16:0] LFSR_SEED = 17'h00001;

    // Mix width: volume width plus enough headroom for every tone channel and the noise source.
    function automatic int mix_width(input int ch, input int vol_w);
        return vol_w + $clog2(ch + 2);
    endfunction

endpackage

// File: rtl/psg_tone_bank_if.sv
// CPU-side register write bus of the PSG tone bank.
interface psg_tone_bank_if #(
    parameter int CHANNELS = 3,
    parameter int PERIOD_W = 10
);
    localparam int CH_W = $clog2(CHANNELS + 1);

    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic                wr_sel;
    logic [PERIOD_W-1:0] wr_data;

    modport master (output wr_en, output wr_ch, output wr_sel, output wr_data);
    modport slave  (input  wr_en, input  wr_ch, input  wr_sel, input  wr_data);
endinterface

// File: rtl/psg_tone_channel.sv
// One square-wave divider: period/volume registers, down-counter and tone flop.
// reload pulses in the cycle the counter is reloaded (tone toggles at that edge).
module psg_tone_channel #(
    parameter int PERIOD_W = 10,
    parameter int VOL_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_en,
    input  logic                period_we,
    input  logic                vol_we,
    input  logic [PERIOD_W-1:0] wr_data,
    output logic                tone,
    output logic [VOL_W-1:0]    vol,
    output logic                reload
);
    logic [PERIOD_W-1:0] period_reg;
    logic [PERIOD_W-1:0] count_reg;
    logic                tone_reg;
    logic [VOL_W-1:0]    vol_reg;

    // A zero period halts the channel; otherwise a reload happens when the count has run out.
    assign reload = tick_en && (period_reg != '0) && (count_reg == '0);
    assign tone   = tone_reg;
    assign vol    = vol_reg;

    // Register writes and the divider step; a reload in the write cycle still sees the old period.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_reg <= '0;
            count_reg  <= '0;
            tone_reg   <= 1'b0;
            vol_reg    <= '0;
        end else begin
            if (period_we) begin
                period_reg <= wr_data;
            end
            if (vol_we) begin
                vol_reg <= wr_data[VOL_W-1:0];
            end
            if (tick_en && (period_reg != '0)) begin
                if (count_reg == '0) begin
                    count_reg <= period_reg;
                    tone_reg  <= ~tone_reg;
                end else begin
                    count_reg <= count_reg - 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/psg_tone_bank.sv
// Multi-channel PSG tone bank: CHANNELS square-wave dividers, write decode and a registered
// additive mix. Defining PSG_NOISE_EN adds an LFSR noise source at channel index CHANNELS.
module psg_tone_bank
    import psg_pkg::*;
#(
    parameter int  CHANNELS = 3,
    parameter int  PERIOD_W = 10,
    parameter int  VOL_W    = 4,
    localparam int CH_W     = $clog2(CHANNELS + 1),
    localparam int MIX_W    = mix_width(CHANNELS, VOL_W)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_en,
    psg_tone_bank_if.slave      bus,
    output logic [CHANNELS-1:0] tone_out,
    output logic                noise_out,
    output logic [MIX_W-1:0]    audio_out
);
    logic [VOL_W-1:0]    vol_arr [CHANNELS];
    logic [CHANNELS-1:0] reload_unused;
    logic [MIX_W-1:0]    noise_term;
    logic [MIX_W-1:0]    mix_next;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic hit;
        assign hit = bus.wr_en && (bus.wr_ch == CH_W'(gi));

        psg_tone_channel #(
            .PERIOD_W (PERIOD_W),
            .VOL_W    (VOL_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .tick_en   (tick_en),
            .period_we (hit && (bus.wr_sel == WR_SEL_PERIOD)),
            .vol_we    (hit && (bus.wr_sel == WR_SEL_VOL)),
            .wr_data   (bus.wr_data),
            .tone      (tone_out[gi]),
            .vol       (vol_arr[gi]),
            .reload    (reload_unused[gi])
        );
    end

`ifdef PSG_NOISE_EN
    logic              noise_hit;
    logic              noise_reload;
    logic              noise_tone_unused;
    logic [VOL_W-1:0]  noise_vol;
    logic [LFSR_W-1:0] lfsr_reg;

    assign noise_hit = bus.wr_en && (bus.wr_ch == CH_W'(CHANNELS));

    psg_tone_channel #(
        .PERIOD_W (PERIOD_W),
        .VOL_W    (VOL_W)
    ) u_noise (
        .clk       (clk),
        .reset     (reset),
        .tick_en   (tick_en),
        .period_we (noise_hit && (bus.wr_sel == WR_SEL_PERIOD)),
        .vol_we    (noise_hit && (bus.wr_sel == WR_SEL_VOL)),
        .wr_data   (bus.wr_data),
        .tone      (noise_tone_unused),
        .vol       (noise_vol),
        .reload    (noise_reload)
    );

    // The noise divider clocks the LFSR once per reload instead of toggling an output.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else if (noise_reload) begin
            lfsr_reg <= {lfsr_reg[0] ^ lfsr_reg[3], lfsr_reg[LFSR_W-1:1]};
        end
    end

    assign noise_out  = lfsr_reg[0];
    assign noise_term = noise_out ? MIX_W'(noise_vol) : '0;
`else
    assign noise_out  = 1'b0;
    assign noise_term = '0;
`endif

    // Sum the volumes of every source whose output is currently high.
    always_comb begin
        mix_next = noise_term;
        for (int i = 0; i < CHANNELS; i++) begin
            if (tone_out[i]) begin
                mix_next = mix_next + MIX_W'(vol_arr[i]);
            end
        end
    end

    // Mix is registered every clock, independent of the prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            audio_out <= '0;
        end else begin
            audio_out <= mix_next;
        end
    end
endmodule
